// File: rtl/cas_converter_pkg.sv
// Shared constants for the ADC-to-float32 conversion stage: float32 bias, zero-case
// encodings, the e*ln2 constant table and the handshake FSM state encoding.
package cas_converter_pkg;

   localparam int          FP_BIAS = 127;
   localparam int          FIX_W   = 12;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_DONE  = 2'd2,
      ST_START = 2'd3
   } state_t;

   typedef struct packed {
      logic       sign;
      logic [7:0] expo;
      logic [22:0] frac;
   } fp32_t;

   // float32(e*ln2), round-to-nearest; e = 0 doubles as the zero-sample entry.
   function automatic logic [31:0] ln2_term(input logic signed [4:0] e);
      logic [31:0] r;
      r = FP_ZERO;
      case (e)
         5'sd0:   r = FP_ZERO;
         -5'sd1:  r = 32'hBF31_7218;
         -5'sd2:  r = 32'hBFB1_7218;
         -5'sd3:  r = 32'hC005_1592;
         -5'sd4:  r = 32'hC031_7218;
         -5'sd5:  r = 32'hC05D_CE9E;
         -5'sd6:  r = 32'hC085_1592;
         -5'sd7:  r = 32'hC09B_43D5;
         -5'sd8:  r = 32'hC0B1_7218;
         -5'sd9:  r = 32'hC0C7_A05B;
         -5'sd10: r = 32'hC0DD_CE9E;
         -5'sd11: r = 32'hC0F3_FCE1;
         -5'sd12: r = 32'hC105_1592;
         default: r = FP_ZERO;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cas_fix2float.sv
// Combinational 12-bit unsigned fraction (x/4096) to float32 normalizer; exact, no rounding.
// Also exposes the unbiased exponent and left-aligned fraction for the log split.
module cas_fix2float
   import cas_converter_pkg::*;
(
   input  logic [11:0]       x_i,
   output logic signed [4:0] e_o,
   output logic [22:0]       frac_o,
   output logic [31:0]       result_o
);

   logic [3:0] p;
   logic       zero;
   fp32_t      fp;

   always_comb begin
      p = 4'd0;
      for (int b = 0; b < FIX_W; b++) begin
         if (x_i[b]) p = 4'(b);
      end
   end

   assign zero = (x_i == 12'd0);
   assign e_o  = $signed({1'b0, p}) - 5'sd12;

   // Shifting the MSB just past bit 22 drops the hidden one and left-aligns the rest.
   assign frac_o = {x_i, 11'b0} << (4'd12 - p);

   always_comb begin
      fp.sign  = 1'b0;
      fp.expo  = 8'(FP_BIAS - FIX_W) + {4'b0, p};
      fp.frac  = frac_o;
      result_o = zero ? FP_ZERO : fp;
   end

endmodule

// File: rtl/cas_converter.sv
// Latches I/V on EOC, converts to float32 (plus V mantissa and e*ln2) in one CONV cycle,
// holds results with ACK_CAS_I/V until each theta block acks, then requests the next ADC sample.
module cas_converter
   import cas_converter_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [11:0] I,
   input  logic [11:0] V,
   input  logic        EOC,
   input  logic        ACK_THETA_I,
   input  logic        ACK_THETA_V,
   output logic        ACK_CAS_I,
   output logic        ACK_CAS_V,
   output logic        START_ADC,
   output logic [31:0] RESULT_V,
   output logic [31:0] MANTISSA,
   output logic [31:0] EXP
);

   state_t      state_q;
   logic [11:0] i_q, v_q;
   logic [31:0] res_i_q, res_v_q, mant_q, exp_q;
   logic        pend_i_q, pend_v_q;
   logic        ack_i_q, ack_v_q, start_q;

   logic signed [4:0] i_e, v_e;
   logic [22:0]       i_frac, v_frac;
   logic [31:0]       res_i_d, res_v_d, mant_d, exp_d;
   logic              pend_i_d, pend_v_d;
   logic              unused_i_side;

   cas_fix2float u_conv_i (
      .x_i      (i_q),
      .e_o      (i_e),
      .frac_o   (i_frac),
      .result_o (res_i_d)
   );

   cas_fix2float u_conv_v (
      .x_i      (v_q),
      .e_o      (v_e),
      .frac_o   (v_frac),
      .result_o (res_v_d)
   );

   always_comb begin
      mant_d   = FP_ONE;
      exp_d    = FP_ZERO;
      if (v_q != 12'd0) begin
         mant_d = {1'b0, 8'(FP_BIAS), v_frac};
         exp_d  = ln2_term(v_e);
      end
      pend_i_d = pend_i_q & ~ACK_THETA_I;
      pend_v_d = pend_v_q & ~ACK_THETA_V;
   end

   // The I result is kept for hierarchical observation only; nothing downstream reads it.
   assign unused_i_side = ^{res_i_q, i_e, i_frac};

   // Handshake outputs trail the pending flags by one edge; START_ADC drops on the EOC edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         i_q      <= '0;
         v_q      <= '0;
         res_i_q  <= '0;
         res_v_q  <= '0;
         mant_q   <= '0;
         exp_q    <= '0;
         pend_i_q <= 1'b0;
         pend_v_q <= 1'b0;
         ack_i_q  <= 1'b0;
         ack_v_q  <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         ack_i_q <= pend_i_q;
         ack_v_q <= pend_v_q;
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (EOC) begin
                  i_q     <= I;
                  v_q     <= V;
                  state_q <= ST_CONV;
               end
            end
            ST_CONV: begin
               res_i_q  <= res_i_d;
               res_v_q  <= res_v_d;
               mant_q   <= mant_d;
               exp_q    <= exp_d;
               pend_i_q <= 1'b1;
               pend_v_q <= 1'b1;
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               pend_i_q <= pend_i_d;
               pend_v_q <= pend_v_d;
               if (!pend_i_d && !pend_v_d) state_q <= ST_START;
            end
            ST_START: begin
               if (EOC) begin
                  i_q     <= I;
                  v_q     <= V;
                  state_q <= ST_CONV;
               end else begin
                  start_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ACK_CAS_I = ack_i_q;
   assign ACK_CAS_V = ack_v_q;
   assign START_ADC = start_q;
   assign RESULT_V  = res_v_q;
   assign MANTISSA  = mant_q;
   assign EXP       = exp_q;

endmodule

// File: tb/tb_cas_converter.sv
// Randomized scoreboard bench for cas_converter; reference values come from real arithmetic.
module tb_cas_converter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [11:0] I = '0, V = '0;
   logic        EOC = 1'b0, ACK_THETA_I = 1'b0, ACK_THETA_V = 1'b0;
   logic        ACK_CAS_I, ACK_CAS_V, START_ADC;
   logic [31:0] RESULT_V, MANTISSA, EXP;

   cas_converter dut (
      .CLK(CLK), .RST(RST), .I(I), .V(V), .EOC(EOC),
      .ACK_THETA_I(ACK_THETA_I), .ACK_THETA_V(ACK_THETA_V),
      .ACK_CAS_I(ACK_CAS_I), .ACK_CAS_V(ACK_CAS_V), .START_ADC(START_ADC),
      .RESULT_V(RESULT_V), .MANTISSA(MANTISSA), .EXP(EXP)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res_v, mant, ex, res_i;
      int          t;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   exp_t got;
   int   eoc_t;
   int   fall_i_cyc = -1, fall_v_cyc = -1, rise_st_cyc = -1, fall_st_cyc = -1;
   logic prev_ai = 1'b0, prev_av = 1'b0, prev_st = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Round a double to float32 (round to nearest even); only normal values occur here.
   function automatic logic [31:0] f32(input real r);
      logic [63:0] d;
      logic [22:0] keep;
      logic [28:0] rest;
      logic [7:0]  fe;
      logic        rnd;
      if (r == 0.0) return 32'h0;
      d    = $realtobits(r);
      fe   = 8'(int'(d[62:52]) - 1023 + 127);
      keep = d[51:29];
      rest = d[28:0];
      rnd  = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0]);
      if (rnd) begin
         if (keep == '1) begin
            keep = '0;
            fe   = fe + 8'd1;
         end else begin
            keep = keep + 23'd1;
         end
      end
      return {d[63], fe, keep};
   endfunction

   function automatic void model(input logic [11:0] x, output logic [31:0] res,
                                 output logic [31:0] mant, output logic [31:0] ex);
      real m;
      int  e;
      if (x == 12'd0) begin
         res  = 32'h0;
         mant = 32'h3F80_0000;
         ex   = 32'h0;
         return;
      end
      m   = real'(int'(x)) / 4096.0;
      res = f32(m);
      e   = 0;
      while (m < 1.0) begin
         m = m * 2.0;
         e--;
      end
      mant = f32(m);
      ex   = f32(real'(e) * $ln(2.0));
   endfunction

   function automatic logic [11:0] rand_sample();
      case ($urandom_range(0, 5))
         0:       return 12'h000;
         1:       return 12'hFFF;
         2:       return 12'(1 << $urandom_range(0, 11));
         default: return 12'($urandom);
      endcase
   endfunction

   // Monitor: pops the scoreboard on each ACK_CAS_V rise and logs handshake edges.
   always @(negedge CLK) begin
      if (ACK_CAS_V && !prev_av) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_ack: ACK_CAS_V rose at cycle %0d with nothing expected", cyc);
         end else begin
            got = sb.pop_front();
            chk("result_v", RESULT_V, got.res_v);
            chk("mantissa", MANTISSA, got.mant);
            chk("exp", EXP, got.ex);
            chk("res_i_internal", dut.res_i_q, got.res_i);
            chk("ack_latency", 32'(cyc), 32'(got.t + 2));
            chk("ack_i_with_v", 32'(ACK_CAS_I), 32'd1);
         end
      end
      if (prev_ai && !ACK_CAS_I) fall_i_cyc = cyc;
      if (prev_av && !ACK_CAS_V) fall_v_cyc = cyc;
      if (!prev_st && START_ADC) rise_st_cyc = cyc;
      if (prev_st && !START_ADC) fall_st_cyc = cyc;
      prev_ai = ACK_CAS_I;
      prev_av = ACK_CAS_V;
      prev_st = START_ADC;
   end

   task automatic issue(input logic [11:0] vv, input logic [11:0] ii);
      exp_t        x;
      logic [31:0] d1, d2;
      @(posedge CLK); #1;
      EOC = 1'b1;
      V   = vv;
      I   = ii;
      model(vv, x.res_v, x.mant, x.ex);
      model(ii, x.res_i, d1, d2);
      x.t      = cyc + 1;
      eoc_t    = x.t;
      last_exp = x;
      sb.push_back(x);
      @(posedge CLK); #1;
      EOC = 1'b0;
      V   = 12'($urandom);
      I   = 12'($urandom);
   endtask

   // which = 0: both ACK_CAS high; which = 1: START_ADC high.
   task automatic wait_for(input int which, input string name);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         @(negedge CLK); #1;
         n++;
         ok = (which == 0) ? (ACK_CAS_I && ACK_CAS_V) : START_ADC;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: condition not reached within %0d cycles", name, n);
      end
   endtask

   task automatic run_tx(input logic [11:0] vv, input logic [11:0] ii, input int di,
                         input int dv, input bit pulse, input bit from_start);
      int si, sv, mx;
      si = 0;
      sv = 0;
      mx = (di > dv) ? di : dv;
      issue(vv, ii);
      wait_for(0, "ack_cas");
      if (from_start) chk("start_fall", 32'(fall_st_cyc), 32'(eoc_t));
      if (pulse) begin
         @(posedge CLK); #1;
         EOC = 1'b1;
         V   = ~vv;
         I   = ~ii;
         @(posedge CLK); #1;
         EOC = 1'b0;
         @(negedge CLK);
         chk("eoc_ignored_result", RESULT_V, last_exp.res_v);
         chk("eoc_ignored_ack", 32'(ACK_CAS_V), 32'd1);
      end
      for (int c = 0; c <= mx; c++) begin
         @(posedge CLK); #1;
         ACK_THETA_I = (c == di);
         ACK_THETA_V = (c == dv);
         if (c == di) si = cyc + 1;
         if (c == dv) sv = cyc + 1;
      end
      @(posedge CLK); #1;
      ACK_THETA_I = 1'b0;
      ACK_THETA_V = 1'b0;
      wait_for(1, "start_adc");
      chk("ack_i_fall", 32'(fall_i_cyc), 32'(si + 1));
      chk("ack_v_fall", 32'(fall_v_cyc), 32'(sv + 1));
      chk("start_rise", 32'(rise_st_cyc), 32'(((si > sv) ? si : sv) + 1));
      chk("hold_while_start", RESULT_V, last_exp.res_v);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack_i"}, 32'(ACK_CAS_I), 32'd0);
      chk({tag, "_ack_v"}, 32'(ACK_CAS_V), 32'd0);
      chk({tag, "_start"}, 32'(START_ADC), 32'd0);
      chk({tag, "_result_v"}, RESULT_V, 32'd0);
      chk({tag, "_mantissa"}, MANTISSA, 32'd0);
      chk({tag, "_exp"}, EXP, 32'd0);
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_all_zero("reset");
      @(posedge CLK); #1;
      RST = 1'b0;

      run_tx(12'h800, 12'h123, 0, 3, 1'b0, 1'b0);
      run_tx(12'hC00, 12'h800, 0, 0, 1'b0, 1'b1);
      run_tx(12'h400, 12'h000, 2, 0, 1'b1, 1'b1);
      run_tx(12'h000, 12'hFFF, 1, 1, 1'b0, 1'b1);
      repeat (30) begin
         run_tx(rand_sample(), rand_sample(), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'b1);
      end

      issue(12'h9A5, 12'h055);
      wait_for(0, "ack_cas_pre_reset");
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check_all_zero("mid_reset");
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      chk("no_self_start", 32'(START_ADC), 32'd0);
      run_tx(12'h001, 12'hFFF, 3, 1, 1'b0, 1'b0);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results never acknowledged", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
